// File: rtl/lc3_mem_pkg.sv
// Shared memory-phase encoding used by the pipeline controller and the memory access unit.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    MEM_RD   = 2'd0,
    MEM_IND  = 2'd1,
    MEM_WR   = 2'd2,
    MEM_IDLE = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Memory access unit: runs one data-memory transaction per controller phase, keeping the
// indirect pointer from an LDI/STI first phase for the following read or write phase.
module mem_access_unit
  import lc3_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_state,
  input  logic [15:0] M_Addr,
  input  logic [15:0] M_Data,
  input  logic [15:0] dmem_dout,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        dmem_rd,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_din,
  output logic [15:0] memout,
  output logic        complete_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t     state, state_next;
  mem_state_t ms;
  mem_state_t phase;
  logic [15:0] ptr;
  logic        ptr_valid;
  logic        start;
  logic        finish;

  assign ms = mem_state_t'(mem_state);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (ms != MEM_IDLE) begin
          start      = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (dmem_ready) begin
          finish     = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        // Leave only once the controller has moved off this phase, so a phase issues one request.
        if (ms != phase) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase     <= MEM_IDLE;
      dmem_rd   <= 1'b1;
      dmem_addr <= '0;
      dmem_din  <= '0;
      memout    <= '0;
      ptr       <= '0;
      ptr_valid <= 1'b0;
    end else begin
      if (start) begin
        phase     <= ms;
        dmem_rd   <= (ms != MEM_WR);
        dmem_din  <= M_Data;
        dmem_addr <= (ptr_valid && (ms == MEM_RD || ms == MEM_WR)) ? ptr : M_Addr;
      end
      if (state == S_IDLE && ms == MEM_IDLE) ptr_valid <= 1'b0;
      if (finish) begin
        case (phase)
          MEM_RD: begin
            memout    <= dmem_dout;
            ptr_valid <= 1'b0;
          end
          MEM_IND: begin
            ptr       <= dmem_dout;
            ptr_valid <= 1'b1;
          end
          MEM_WR:  ptr_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign dmem_req      = (state == S_REQ);
  assign complete_data = (state == S_DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a phase-level model predicts each memory request and
// each completed memout; a negedge monitor compares them as the DUT presents them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_state;
  logic [15:0] M_Addr, M_Data, dmem_dout;
  logic        dmem_ready;
  logic        dmem_req, dmem_rd, complete_data;
  logic [15:0] dmem_addr, dmem_din, memout;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .mem_state(mem_state), .M_Addr(M_Addr), .M_Data(M_Data),
    .dmem_dout(dmem_dout), .dmem_ready(dmem_ready), .dmem_req(dmem_req), .dmem_rd(dmem_rd),
    .dmem_addr(dmem_addr), .dmem_din(dmem_din), .memout(memout), .complete_data(complete_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic        rd;
    logic [15:0] din;
  } req_t;

  req_t        exp_req_q[$];
  logic [15:0] exp_out_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model of the phase-level contract.
  logic [15:0] m_ptr = '0;
  logic [15:0] m_out = '0;
  bit          m_pv = 0;
  bit          in_done = 0;
  logic [1:0]  prev_ph = 2'd3;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic summary_and_finish();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic push_req(input logic [1:0] ph, input logic [15:0] addr, input logic [15:0] data);
    req_t e;
    e.addr = (ph != 2'd1 && m_pv) ? m_ptr : addr;
    e.rd   = (ph != 2'd2);
    e.din  = data;
    exp_req_q.push_back(e);
  endtask

  task automatic idle_gap(input int n);
    mem_state = 2'd3;
    for (int i = 0; i < n; i++) begin
      dmem_ready = 1'($urandom_range(0, 1));
      dmem_dout  = 16'($urandom);
      @(posedge clk); #1;
      chk("idle_quiet", {31'd0, complete_data, dmem_req}, 33'd0);
    end
    dmem_ready = 1'b0;
    if (n > (in_done ? 1 : 0)) m_pv = 0;
    in_done = 0;
  endtask

  task automatic start_phase(input logic [1:0] ph, input logic [15:0] addr, input logic [15:0] data);
    if (in_done && ph == prev_ph) idle_gap(2);
    push_req(ph, addr, data);
    mem_state = ph;
    M_Addr    = addr;
    M_Data    = data;
    if (in_done) begin
      @(posedge clk); #1;
      chk("done_drop", {32'd0, complete_data}, 33'd0);
      in_done = 0;
    end
  endtask

  task automatic finish_phase(input logic [1:0] ph, input logic [15:0] dout, input int delay,
                              input bit toggle);
    int cnt = 0;
    int stay;
    while (!dmem_req && cnt < 8) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!dmem_req) begin
      n_vec++;
      n_err++;
      $display("FAIL req_timeout: got dmem_req=0 expected 1 within 8 cycles");
      summary_and_finish();
    end
    M_Addr = 16'($urandom);
    M_Data = 16'($urandom);
    for (int i = 0; i < delay; i++) begin
      if (toggle) mem_state = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    mem_state  = ph;
    dmem_ready = 1'b1;
    dmem_dout  = dout;
    case (ph)
      2'd0: begin m_out = dout; m_pv = 0; end
      2'd1: begin m_ptr = dout; m_pv = 1; end
      default: m_pv = 0;
    endcase
    exp_out_q.push_back(m_out);
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    dmem_dout  = 16'($urandom);
    chk("done_entry", {31'd0, complete_data, dmem_req}, 33'd2);
    stay = $urandom_range(0, 3);
    for (int i = 0; i < stay; i++) begin
      dmem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("done_hold", {31'd0, complete_data, dmem_req}, 33'd2);
    end
    dmem_ready = 1'b0;
    in_done = 1;
    prev_ph = ph;
  endtask

  task automatic do_phase(input logic [1:0] ph, input logic [15:0] addr, input logic [15:0] data,
                          input logic [15:0] dout, input int delay, input bit toggle);
    start_phase(ph, addr, data);
    finish_phase(ph, dout, delay, toggle);
  endtask

  // Monitor: one expected request per rising dmem_req, stable while held; one memout per completion.
  req_t cur_req;
  logic prev_req = 1'b0;
  logic prev_cd  = 1'b0;
  always @(negedge clk) begin
    if (dmem_req && !prev_req) begin
      if (exp_req_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_req: got addr %h rd %b din %h expected no request",
                 dmem_addr, dmem_rd, dmem_din);
      end else begin
        cur_req = exp_req_q.pop_front();
        chk("req_fields", {dmem_addr, dmem_rd, dmem_din}, cur_req);
      end
    end else if (dmem_req && prev_req) begin
      chk("req_stable", {dmem_addr, dmem_rd, dmem_din}, cur_req);
    end
    if (complete_data && !prev_cd) begin
      if (exp_out_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got complete_data=1 expected 0");
      end else begin
        chk("memout", {17'd0, memout}, {17'd0, exp_out_q.pop_front()});
      end
    end
    prev_req = dmem_req;
    prev_cd  = complete_data;
  end

  initial begin
    #2_000_000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: got simulation still running expected finish");
    summary_and_finish();
  end

  initial begin
    rst        = 1'b0;
    mem_state  = 2'd3;
    M_Addr     = 16'h5A5A;
    M_Data     = 16'hA5A5;
    dmem_dout  = 16'hFFFF;
    dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {30'd0, dmem_req, complete_data, dmem_rd}, 33'd1);
    chk("reset_addr_din", {1'b0, dmem_addr, dmem_din}, 33'd0);
    chk("reset_memout", {17'd0, memout}, 33'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Read with ready three cycles into the request.
    do_phase(2'd0, 16'h3000, 16'h0000, 16'hBEEF, 3, 0);
    chk("read_memout", {17'd0, memout}, {17'd0, 16'hBEEF});
    idle_gap(2);

    // Zero-wait write.
    do_phase(2'd2, 16'h4001, 16'h1234, 16'hDEAD, 0, 0);
    idle_gap(2);

    // LDI, then a write at a fresh address proves the pointer was consumed.
    do_phase(2'd1, 16'h3010, 16'h0000, 16'h5000, 1, 0);
    do_phase(2'd0, 16'h1111, 16'h0000, 16'h00AA, 2, 0);
    chk("ldi_memout", {17'd0, memout}, {17'd0, 16'h00AA});
    do_phase(2'd2, 16'h2468, 16'h9999, 16'h0000, 0, 0);
    idle_gap(2);

    // STI.
    do_phase(2'd1, 16'h3020, 16'h0000, 16'h6000, 0, 0);
    do_phase(2'd2, 16'h1357, 16'h7777, 16'h0000, 1, 0);
    idle_gap(3);

    // Phase code toggled while a request is in flight.
    do_phase(2'd0, 16'h2000, 16'h0000, 16'h4321, 4, 1);
    idle_gap(2);

    // Reset in the middle of a pointer-based request, then restart from M_Addr.
    do_phase(2'd1, 16'h3030, 16'h0000, 16'h8000, 0, 0);
    start_phase(2'd0, 16'h4444, 16'h0000);
    begin
      int cnt = 0;
      while (!dmem_req && cnt < 8) begin
        @(posedge clk); #1;
        cnt++;
      end
    end
    chk("midreset_req_up", {32'd0, dmem_req}, 33'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midreset_ctrl", {30'd0, dmem_req, complete_data, dmem_rd}, 33'd1);
    chk("midreset_memout", {17'd0, memout}, 33'd0);
    rst   = 1'b1;
    m_pv  = 0;
    m_ptr = '0;
    m_out = '0;
    in_done = 0;
    push_req(2'd0, 16'h4444, 16'h0000);
    finish_phase(2'd0, 16'h0F0F, 1, 0);
    idle_gap(2);

    // Randomized phases, including pointer pairs and idle gaps with stray ready pulses.
    for (int i = 0; i < 200; i++) begin
      logic [1:0] ph;
      ph = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
      do_phase(ph, 16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 4),
               1'($urandom_range(0, 1)));
    end
    idle_gap(3);

    repeat (2) @(posedge clk);
    #1;
    chk("req_queue_empty", 33'(exp_req_q.size()), 33'd0);
    chk("out_queue_empty", 33'(exp_out_q.size()), 33'd0);
    summary_and_finish();
  end

endmodule
